// File: rtl/uart_rx_ctrl.sv
// Wishbone-slave receive controller: buffers bytes from uart_rx in a FIFO and
// exposes data/status/control/timeout registers with a level/timeout/overrun IRQ.
module uart_rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int LGFIFO       = 4,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_rx_data,
    input  logic                 i_rx_ready,
    input  logic                 i_rx_busy,
    output logic                 o_rx_enable,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [1:0]           i_wb_addr,
    input  logic [31:0]          i_wb_data,
    output logic                 o_wb_ack,
    output logic                 o_wb_stall,
    output logic [31:0]          o_wb_data,
    output logic                 o_irq
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0]       LVL_ONE = {{LGFIFO{1'b0}}, 1'b1};
    localparam logic [LGFIFO-1:0]     PTR_ONE = {{(LGFIFO-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_BITS-1:0] TO_ONE = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] A_RXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_CONTROL = 2'd2;
    localparam logic [1:0] A_TIMEOUT = 2'd3;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [LGFIFO-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]         level_q, level_d;
    logic                    rx_en_q, rx_en_d;
    logic                    lvl_en_q, lvl_en_d;
    logic                    to_en_q, to_en_d;
    logic                    ovr_en_q, ovr_en_d;
    logic [7:0]              thr_q, thr_d;
    logic [TIMEOUT_BITS-1:0] reload_q, reload_d;
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
    logic                    ovr_flag_q, ovr_flag_d;
    logic                    to_flag_q, to_flag_d;
    logic                    ack_q, ack_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    irq_q, irq_d;

    logic req, rd_req, wr_req;
    logic empty, full, pop, push, flush, strobe;
    logic ovr_set, ovr_clr, to_set, to_clr;
    logic [7:0]  level8;
    logic [31:0] rmux;
    logic        unused_wb_bits;

    assign unused_wb_bits = ^i_wb_data;

    assign req    = i_wb_cyc & i_wb_stb;
    assign rd_req = req & ~i_wb_we;
    assign wr_req = req & i_wb_we;
    assign empty  = (level_q == '0);
    assign full   = level_q[LGFIFO];
    assign pop    = rd_req & (i_wb_addr == A_RXDATA) & ~empty;
    assign flush  = wr_req & (i_wb_addr == A_CONTROL) & i_wb_data[4];
    assign strobe = i_rx_ready & rx_en_q;
    // A pop on a full FIFO frees the slot being written at the same edge.
    assign push    = strobe & ~flush & (~full | pop);
    assign ovr_set = strobe & ~flush & full & ~pop;
    assign ovr_clr = wr_req & (i_wb_addr == A_STATUS) & i_wb_data[2];
    assign to_clr  = wr_req & (i_wb_addr == A_STATUS) & i_wb_data[3];

    always_comb begin
        level8 = '0;
        level8[LGFIFO:0] = level_q;
    end

    always_comb begin
        rmux = '0;
        case (i_wb_addr)
            A_RXDATA: begin
                if (!empty) begin
                    rmux[DATA_BITS-1:0] = mem[rd_ptr_q];
                    rmux[31]            = 1'b1;
                end
            end
            A_STATUS: begin
                rmux[0]    = ~empty;
                rmux[1]    = full;
                rmux[2]    = ovr_flag_q;
                rmux[3]    = to_flag_q;
                rmux[4]    = i_rx_busy;
                rmux[15:8] = level8;
            end
            A_CONTROL: begin
                rmux[0]    = rx_en_q;
                rmux[1]    = lvl_en_q;
                rmux[2]    = to_en_q;
                rmux[3]    = ovr_en_q;
                rmux[15:8] = thr_q;
            end
            default: rmux[TIMEOUT_BITS-1:0] = reload_q;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rx_en_d    = rx_en_q;
        lvl_en_d   = lvl_en_q;
        to_en_d    = to_en_q;
        ovr_en_d   = ovr_en_q;
        thr_d      = thr_q;
        reload_d   = reload_q;
        cnt_d      = cnt_q;
        to_set     = 1'b0;
        ack_d      = req;
        rdata_d    = rd_req ? rmux : '0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LVL_ONE;
            else if (pop && !push) level_d = level_q - LVL_ONE;
        end

        if (wr_req && i_wb_addr == A_CONTROL) begin
            rx_en_d  = i_wb_data[0];
            lvl_en_d = i_wb_data[1];
            to_en_d  = i_wb_data[2];
            ovr_en_d = i_wb_data[3];
            thr_d    = i_wb_data[15:8];
        end
        if (wr_req && i_wb_addr == A_TIMEOUT)
            reload_d = i_wb_data[TIMEOUT_BITS-1:0];

        // Idle timer: terminal count 1->0 flags a stalled, unread FIFO.
        if (push || pop || empty) begin
            cnt_d = reload_q;
        end else if (reload_q != '0 && cnt_q != '0) begin
            cnt_d  = cnt_q - TO_ONE;
            to_set = (cnt_q == TO_ONE);
        end

        ovr_flag_d = ovr_set | (ovr_flag_q & ~ovr_clr);
        to_flag_d  = to_set  | (to_flag_q  & ~to_clr);

        irq_d = (lvl_en_q & (thr_q != '0) & (level8 >= thr_q))
              | (to_en_q & to_flag_q)
              | (ovr_en_q & ovr_flag_q);
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_en_q    <= 1'b0;
            lvl_en_q   <= 1'b0;
            to_en_q    <= 1'b0;
            ovr_en_q   <= 1'b0;
            thr_q      <= 8'd1;
            reload_q   <= '0;
            cnt_q      <= '0;
            ovr_flag_q <= 1'b0;
            to_flag_q  <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_en_q    <= rx_en_d;
            lvl_en_q   <= lvl_en_d;
            to_en_q    <= to_en_d;
            ovr_en_q   <= ovr_en_d;
            thr_q      <= thr_d;
            reload_q   <= reload_d;
            cnt_q      <= cnt_d;
            ovr_flag_q <= ovr_flag_d;
            to_flag_q  <= to_flag_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign o_rx_enable = rx_en_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = rdata_q;
    assign o_irq       = irq_q;

endmodule
